// File: rtl/float_to_fixed_pipe.sv
// float_to_fixed_pipe: 3-stage IEEE-754 single to signed Q(INT_W).(FRAC_W) converter with valid/ready.
// Define F2F_ROUND_EN for round-half-away-from-zero; by default the magnitude is truncated.
module float_to_fixed_pipe #(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INT_W+FRAC_W-1:0]   out_data,
    output logic                      out_ovf,
    output logic                      out_nan
);
    localparam int W = INT_W + FRAC_W;
    localparam logic [W:0] MAX_P = {2'b00, {(W-1){1'b1}}};
    localparam logic [W:0] MAX_N = {2'b01, {(W-1){1'b0}}};
    localparam logic signed [8:0] E_MAX = 9'(INT_W - 1);
    localparam logic [10:0] SH_OFF = 11'(FRAC_W - 22);
`ifdef F2F_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic               r1_v, r1_sign, r1_nan, r1_inf, r1_mz;
    logic [23:0]        r1_sig;
    logic signed [8:0]  r1_e;
    logic               r2_v, r2_sign, r2_nan, r2_povf, r2_g;
    logic [W-1:0]       r2_mag;
    logic               w_adv1, w_adv2, w_adv3;
    logic signed [10:0] w_sh;
    logic [10:0]        w_rsh;
    logic [W:0]         w_ext;
    logic               w_povf;
    logic [W:0]         w_r;
    logic               w_o;
    logic [W-1:0]       w_d;

    assign w_adv3   = out_ready | ~out_valid;
    assign w_adv2   = ~r2_v | w_adv3;
    assign w_adv1   = ~r1_v | w_adv2;
    assign in_ready = w_adv1;

    // Shift that places the guard bit at w_ext[0]; zero/denormal exponents shift everything out.
    assign w_sh  = {{2{r1_e[8]}}, r1_e} + SH_OFF;
    assign w_rsh = -w_sh;

    always_comb begin
        w_ext  = w_sh[10] ? (W+1)'(r1_sig >> w_rsh) : (W+1)'({{(W+1){1'b0}}, r1_sig} << w_sh);
        w_povf = r1_inf | (r1_e >= E_MAX && !(r1_e == E_MAX && r1_mz && r1_sign));
        w_r    = {1'b0, r2_mag} + (W+1)'(ROUND & r2_g);
        w_o    = r2_povf | (w_r > (r2_sign ? MAX_N : MAX_P));
        w_d    = w_o ? (r2_sign ? MAX_N[W-1:0] : MAX_P[W-1:0]) : (r2_sign ? W'(-w_r) : w_r[W-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_v    <= 1'b0;
            r1_sign <= 1'b0;
            r1_nan  <= 1'b0;
            r1_inf  <= 1'b0;
            r1_mz   <= 1'b0;
            r1_sig  <= '0;
            r1_e    <= '0;
        end else if (w_adv1) begin
            r1_v <= in_valid;
            if (in_valid) begin
                r1_sign <= in_data[31];
                r1_nan  <= (&in_data[30:23]) & (|in_data[22:0]);
                r1_inf  <= (&in_data[30:23]) & ~(|in_data[22:0]);
                r1_mz   <= ~(|in_data[22:0]);
                r1_sig  <= {1'b1, in_data[22:0]};
                r1_e    <= 9'({1'b0, in_data[30:23]} - 9'd127);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_v    <= 1'b0;
            r2_sign <= 1'b0;
            r2_nan  <= 1'b0;
            r2_povf <= 1'b0;
            r2_g    <= 1'b0;
            r2_mag  <= '0;
        end else if (w_adv2) begin
            r2_v <= r1_v;
            if (r1_v) begin
                r2_sign <= r1_sign;
                r2_nan  <= r1_nan;
                r2_povf <= w_povf;
                r2_g    <= w_ext[0];
                r2_mag  <= w_ext[W:1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_nan   <= 1'b0;
        end else if (w_adv3) begin
            out_valid <= r2_v;
            if (r2_v) begin
                out_data <= r2_nan ? '0 : w_d;
                out_ovf  <= ~r2_nan & w_o;
                out_nan  <= r2_nan;
            end
        end
    end
endmodule
